// File: rtl/pbridge_pkg.sv
// ============================================================================
// Module   : pbridge_pkg
// Brief    : Shared types and constants for the peripheral bus bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pbridge_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BE_W           = 4;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WIN_SIZE       = 32;
  localparam int unsigned PADDR_W        = 5;

  localparam logic [PADDR_W-1:0] OFF_DIN    = 5'd0;
  localparam logic [PADDR_W-1:0] OFF_DOUT   = 5'd4;
  localparam logic [PADDR_W-1:0] OFF_TIMER0 = 5'd8;
  localparam logic [PADDR_W-1:0] OFF_TIMER1 = 5'd12;
  localparam logic [PADDR_W-1:0] OFF_PWM0   = 5'd16;
  localparam logic [PADDR_W-1:0] OFF_ADOUT  = 5'd20;
  localparam logic [PADDR_W-1:0] OFF_7SEG   = 5'd24;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WR     = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/periph_bus_bridge_if.sv
// ============================================================================
// Module   : periph_bus_bridge_if
// Brief    : CPU-side request/response handshake of the peripheral bus bridge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface periph_bus_bridge_if;
  import pbridge_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

`default_nettype wire

// File: rtl/pbridge_merge.sv
// ============================================================================
// Module   : pbridge_merge
// Brief    : Byte-lane merge of an old and a new word under byte enables.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pbridge_merge
  import pbridge_pkg::*;
(
  input  wire logic [DATA_W-1:0] i_old,
  input  wire logic [DATA_W-1:0] i_new,
  input  wire logic [BE_W-1:0]   i_be,
  output logic      [DATA_W-1:0] o_merged
);

  for (genvar n = 0; n < BYTES_PER_WORD; n++) begin : g_lane
    assign o_merged[8*n +: 8] = i_be[n] ? i_new[8*n +: 8] : i_old[8*n +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/periph_bus_bridge.sv
// ============================================================================
// Module   : periph_bus_bridge
// Brief    : CPU load/store to registered 5-bit peripheral bus bridge.
//            Define PBRIDGE_RMW_EN to enable read-modify-write sub-word stores.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module periph_bus_bridge
  import pbridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  periph_bus_bridge_if.slave      s_bus,
  output logic      [PADDR_W-1:0] A,
  output logic      [DATA_W-1:0]  WD,
  output logic                    WE,
  input  wire logic [DATA_W-1:0]  RD
);

  state_t              r_state;
  state_t              w_next;
  logic                w_accept;
  logic                w_err;
  logic                w_be_bad;
  logic                w_full;
  logic [PADDR_W-1:0]  r_a;
  logic [DATA_W-1:0]   r_wd;
  logic                r_we;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic                r_rsp_err;

  assign s_bus.req_ready = (r_state == ST_IDLE);
  assign w_accept        = s_bus.req_valid && s_bus.req_ready;
  assign w_full          = (s_bus.req_be == 4'hF);

`ifdef PBRIDGE_RMW_EN
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] w_merged;

  assign w_be_bad = s_bus.req_we && (s_bus.req_be == 4'h0);

  pbridge_merge u_merge (
    .i_old    (RD),
    .i_new    (r_wdata),
    .i_be     (r_be),
    .o_merged (w_merged)
  );
`else
  // Without RMW only whole-word stores can be honoured.
  assign w_be_bad = s_bus.req_we && !w_full;
`endif

  assign w_err = (s_bus.req_addr[31:5] != BASE_ADDR[31:5])
               || (s_bus.req_addr[1:0] != 2'b00)
               || w_be_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_err)              w_next = ST_RESP;
          else if (!s_bus.req_we) w_next = ST_RD;
          else if (w_full)        w_next = ST_WR;
`ifdef PBRIDGE_RMW_EN
          else                    w_next = ST_RMW_RD;
`endif
        end
      end
      ST_RD:     w_next = ST_RESP;
`ifdef PBRIDGE_RMW_EN
      ST_RMW_RD: w_next = ST_WR;
`endif
      ST_WR:     w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_wd        <= '0;
      r_we        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
`ifdef PBRIDGE_RMW_EN
      r_be        <= '0;
      r_wdata     <= '0;
`endif
    end else begin
      r_we        <= (w_next == ST_WR);
      r_rsp_valid <= (w_next == ST_RESP);
      if (w_accept) begin
        r_rsp_err   <= w_err;
        r_rsp_rdata <= '0;
`ifdef PBRIDGE_RMW_EN
        r_be        <= s_bus.req_be;
        r_wdata     <= s_bus.req_wdata;
`endif
        if (!w_err) begin
          r_a <= s_bus.req_addr[PADDR_W-1:0];
          if (s_bus.req_we && w_full) r_wd <= s_bus.req_wdata;
        end
      end
      if (r_state == ST_RD) r_rsp_rdata <= RD;
`ifdef PBRIDGE_RMW_EN
      if (r_state == ST_RMW_RD) r_wd <= w_merged;
`endif
    end
  end

  assign A               = r_a;
  assign WD              = r_wd;
  assign WE              = r_we;
  assign s_bus.rsp_valid = r_rsp_valid;
  assign s_bus.rsp_rdata = r_rsp_rdata;
  assign s_bus.rsp_err   = r_rsp_err;

endmodule

`default_nettype wire

// File: tb/tb_periph_bus_bridge.sv
// ============================================================================
// Module   : tb_periph_bus_bridge
// Brief    : Directed self-checking bench for periph_bus_bridge (PBRIDGE_RMW_EN aware).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_periph_bus_bridge;
  import pbridge_pkg::*;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic [31:0] mem [8];
  logic        tb_init = 1'b1;
  int          n_tests = 0;
  int          n_fail  = 0;

  periph_bus_bridge_if bus ();

  periph_bus_bridge #(.BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s_bus (bus),
    .A     (A),
    .WD    (WD),
    .WE    (WE),
    .RD    (RD)
  );

  always #5 clk = ~clk;

  // Peripheral model: offsets 28..31 read as zero.
  assign RD = (A[4:2] == 3'd7) ? 32'h0 : mem[A[4:2]];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h0000_A5A5;
      mem[6] <= 32'h0112_3456;
    end else if (WE) begin
      mem[A[4:2]] <= WD;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents a request for one cycle; returns #1 after the accept edge T.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic err_case(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] be);
    issue(we, addr, 32'hFFFF_FFFF, be);
    @(negedge clk);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1);
    check({tag, "_rsp_err"},   bus.rsp_err,   1);
    check({tag, "_rdata"},     bus.rsp_rdata, 0);
    check({tag, "_we_t1"},     WE,            0);
    @(negedge clk);
    check({tag, "_we_t2"},     WE,            0);
    check({tag, "_rsp_done"},  bus.rsp_valid, 0);
    check({tag, "_ready"},     bus.req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_A",         A,             0);
    check("rst_WD",        WD,            0);
    check("rst_WE",        WE,            0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    check("rst_rsp_err",   bus.rsp_err,   0);
    check("rst_ready",     bus.req_ready, 1);
    @(posedge clk); #1;
    tb_init = 1'b0;
    rst_n   = 1'b1;

    // Load at BASE+0
    issue(1'b0, BASE + 32'd0, 32'h0, 4'h0);
    @(negedge clk);
    check("ld_A_t1",     A,             0);
    check("ld_WE_t1",    WE,            0);
    check("ld_rv_t1",    bus.rsp_valid, 0);
    check("ld_ready_t1", bus.req_ready, 0);
    @(negedge clk);
    check("ld_rv_t2",    bus.rsp_valid, 1);
    check("ld_rdata",    bus.rsp_rdata, 32'h0000_A5A5);
    check("ld_err",      bus.rsp_err,   0);
    check("ld_WE_t2",    WE,            0);
    @(negedge clk);
    check("ld_rv_t3",    bus.rsp_valid, 0);
    check("ld_ready_t3", bus.req_ready, 1);

    // Full store at BASE+4
    issue(1'b1, BASE + 32'd4, 32'h000F_00FF, 4'hF);
    @(negedge clk);
    check("st_WE_t1", WE,            1);
    check("st_A_t1",  A,             4);
    check("st_WD_t1", WD,            32'h000F_00FF);
    check("st_rv_t1", bus.rsp_valid, 0);
    @(negedge clk);
    check("st_WE_t2", WE,            0);
    check("st_rv_t2", bus.rsp_valid, 1);
    check("st_rdata", bus.rsp_rdata, 0);
    check("st_err",   bus.rsp_err,   0);

`ifdef PBRIDGE_RMW_EN
    // Partial store at BASE+24, lane 1 only
    issue(1'b1, BASE + 32'd24, 32'h0000_3C00, 4'b0010);
    @(negedge clk);
    check("rmw_A_t1",  A,             24);
    check("rmw_WE_t1", WE,            0);
    check("rmw_rv_t1", bus.rsp_valid, 0);
    @(negedge clk);
    check("rmw_WE_t2", WE,            1);
    check("rmw_WD_t2", WD,            32'h0112_3C56);
    check("rmw_rv_t2", bus.rsp_valid, 0);
    @(negedge clk);
    check("rmw_WE_t3", WE,            0);
    check("rmw_rv_t3", bus.rsp_valid, 1);
    check("rmw_err",   bus.rsp_err,   0);
    @(negedge clk);
    check("rmw_rv_t4", bus.rsp_valid, 0);
`else
    err_case("err_rmw_disabled", 1'b1, BASE + 32'd24, 4'b0010);
    err_case("err_be3",          1'b1, BASE + 32'd8,  4'h3);
`endif

    err_case("err_range", 1'b0, BASE + 32'h40, 4'h0);
    err_case("err_align", 1'b0, BASE + 32'd2,  4'h0);
    err_case("err_be0",   1'b1, BASE + 32'd8,  4'h0);

    // Offset 28 is legal and reads zero
    issue(1'b0, BASE + 32'd28, 32'h0, 4'h0);
    @(negedge clk);
    check("o28_A", A, 28);
    @(negedge clk);
    check("o28_rv",    bus.rsp_valid, 1);
    check("o28_err",   bus.rsp_err,   0);
    check("o28_rdata", bus.rsp_rdata, 0);
    @(negedge clk);

    // Back-to-back loads with req_valid held; address changes after accept are ignored
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = BASE + 32'd4;
    @(posedge clk); #1;
    bus.req_addr  = BASE + 32'd0;
    @(negedge clk);
    check("b2b_ready_t1", bus.req_ready, 0);
    check("b2b_A_t1",     A,             4);
    @(negedge clk);
    check("b2b_rv1",      bus.rsp_valid, 1);
    check("b2b_rdata1",   bus.rsp_rdata, 32'h000F_00FF);
    check("b2b_ready_t2", bus.req_ready, 0);
    @(negedge clk);
    check("b2b_ready_t3", bus.req_ready, 1);
    check("b2b_rv_t3",    bus.rsp_valid, 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_A2",       A,             0);
    check("b2b_ready_t4", bus.req_ready, 0);
    @(negedge clk);
    check("b2b_rv2",      bus.rsp_valid, 1);
    check("b2b_rdata2",   bus.rsp_rdata, 32'h0000_A5A5);
    @(negedge clk);

    // Reset during the write cycle of a full store
    issue(1'b1, BASE + 32'd12, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("rw_WE_before", WE, 1);
    #1 rst_n = 1'b0;
    #1;
    check("rw_WE_async", WE,            0);
    check("rw_rv_async", bus.rsp_valid, 0);
    @(negedge clk);
    check("rw_rv_rst",   bus.rsp_valid, 0);
    check("rw_WE_rst",   WE,            0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rw_rv_after",    bus.rsp_valid, 0);
    check("rw_ready_after", bus.req_ready, 1);
    issue(1'b0, BASE + 32'd12, 32'h0, 4'h0);
    @(negedge clk);
    check("rw_ld_A", A, 12);
    @(negedge clk);
    check("rw_ld_rv",    bus.rsp_valid, 1);
    check("rw_ld_err",   bus.rsp_err,   0);
    check("rw_ld_rdata", bus.rsp_rdata, 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/periph_bus_bridge.md
# periph_bus_bridge

Initiator side of the peripheral register bus: accepts word/sub-word load/store requests from the CPU data port over a valid/ready handshake and turns them into single, registered peripheral accesses on the 5-bit byte-offset bus (`A`, `WD`, `WE`, `RD`) used by the peripherals block. It range-checks and alignment-checks each request. It performs read-modify-write for sub-word stores. It returns one response per accepted request.

## Interface
- `BASE_ADDR`, default 32'h0001_0000: byte base of the 32-byte peripheral window; bits [4:0] must be zero.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: CPU request present.
- `req_ready` out 1: bridge can accept; equals (state == IDLE).
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, lane-aligned (byte n on bits 8n+7:8n).
- `req_be` in 4: byte enables for stores; ignored for loads.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: load data, valid with `rsp_valid`; 0 on stores and errors.
- `rsp_err` out 1: request rejected, valid with `rsp_valid`.
- `A` out 5: peripheral byte offset, registered.
- `WD` out 32: peripheral write data, registered.
- `WE` out 1: peripheral write strobe, registered.
- `RD` in 32: peripheral read data, combinational from `A`.

## Operation
- States: IDLE, RD, RMW_RD, WR, RESP.
- Accept occurs when `req_valid && req_ready`. The request is latched on that edge.
- Error when any of the following holds:
  - `req_addr[31:5] != BASE_ADDR[31:5]`;
  - `req_addr[1:0] != 0`;
  - store with `req_be == 0`.
- On error: IDLE->RESP with `rsp_err=1`. No peripheral access occurs and `WE` stays 0.
- Load: IDLE->RD->RESP. `A = req_addr[4:0]` during RD. `RD` is captured at the end of RD.
- Full store (`be == 4'hF`): IDLE->WR->RESP. `WE=1` and `WD=req_wdata` during WR only.
- Partial store: IDLE->RMW_RD->WR->RESP.
  - RMW_RD drives `A` and captures `RD`.
  - WR writes the merged word: the byte from `req_wdata` where `be` is set, otherwise the byte from the captured `RD`.
- RESP: `rsp_valid=1` for exactly one cycle, then return to IDLE. There is no response backpressure; the CPU must accept.
- Offsets 28..31 within the window are legal. The peripheral returns 0 and the bridge does not flag them.
- `A` holds its last value in IDLE. `WD` holds its last value. `WE` is 1 only in WR.

## Timing
- Accept at edge T.
- Latencies to `rsp_valid` high:
  - load: cycle T+2, with the peripheral read in T+1;
  - full store: cycle T+2, with `WE` high in T+1;
  - RMW store: cycle T+3, with the read in T+1 and `WE` in T+2;
  - error: cycle T+1.
- `req_ready` is 0 from T+1 until the cycle after RESP. The earliest next accept is in the cycle after RESP.
- Reset values: state IDLE, `A=0`, `WD=0`, `WE=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`. `req_ready=1` combinationally, but nothing is accepted while `rst_n=0`.
- Reset mid-operation: `WE` drops asynchronously and the pending response is discarded. No partial write completes after reset asserts.
- `req_*` inputs are sampled only at the accept edge. Changes afterward are ignored.

## Configuration
- `PBRIDGE_RMW_EN` defined: partial stores use the RMW path as above.
- `PBRIDGE_RMW_EN` undefined:
  - RMW_RD is not built;
  - any store with `be != 4'hF` is an error (RESP at T+1, `rsp_err=1`, no access).

## Structure
- Package `pbridge_pkg`: state enum; peripheral offset constants (DIN 0, DOUT 4, TIMER0 8, TIMER1 12, PWM0 16, ADOUT 20, 7SEG 24); window size 32; `A` width 5.
- Sub-module `pbridge_merge`: combinational byte-lane merge of (old word, new word, be) -> merged word.

## Test plan
- Load at BASE+0 with `RD=32'h0000_A5A5` at `A=0` -> `A=0` in T+1; `rsp_valid` at T+2 with `rsp_rdata=32'h0000_A5A5`, `rsp_err=0`; `WE` never high.
- Store at BASE+4 with data `32'h000F_00FF`, `be=4'hF` -> `WE=1`, `A=4`, `WD=32'h000F_00FF` in T+1 only; `rsp_valid` at T+2 with `rsp_rdata=0`.
- RMW enabled: store at BASE+24 with `be=4'b0010`, data `32'h0000_3C00`, `RD=32'h0112_3456` -> `WD=32'h0112_3C56` in T+2; response at T+3.
- Each error case below gives `rsp_err=1` at T+1 and `WE` stays 0:
  - addr BASE+0x40;
  - addr BASE+2;
  - store with `be=0`;
  - with `PBRIDGE_RMW_EN` undefined, store with `be=4'h3`.
- Back-to-back: `req_valid` held high with two loads -> second accepted the cycle after the first RESP; `req_ready` is 0 in between.
- Assert `rst_n=0` during WR of a full store -> `WE` falls immediately; no `rsp_valid`; after release, `req_ready=1` and the next load completes normally.
